bp_stall_hist_reader: RTL and testbench
=======================================

# bp_stall_hist_reader

Synthesizable per-reason stall histogram with a drain port. It consumes the encoded stall-reason stream that the core profiler produces at the end of its stall pipe: one 5-bit `bp_stall_reason_e` code plus an instret flag per cycle. It keeps a saturating counter per reason and, on request, snapshots the bank and streams (id, count) records out over a valid/yumi interface. It sits beside the core in the tile, so histograms can be read on hardware without simulator file I/O.

## Interface
Parameters:
- num_reasons_p, 21, number of stall reason codes (0..20, matches `bp_stall_reason_e`).
- cnt_width_p, 32, width of each counter.
- Localparam reason_width_lp = `BSG_SAFE_CLOG2(num_reasons_p+1)`, which is 5 at the defaults.
- Localparam num_entries_lp = num_reasons_p+1. Entry id num_reasons_p is the instret counter.

Ports:
- clk_i  in  1  clock.
- reset_li  in  1  reset, asynchronous, active-low.
- freeze_i  in  1  core frozen; no counting while high.
- stall_v_i  in  1  stall_reason_i is valid this cycle.
- stall_reason_i  in  reason_width_lp  encoded stall reason.
- instret_i  in  1  instruction retired this cycle.
- dump_v_i  in  1  dump request.
- dump_ready_o  out  1  dump request can be accepted.
- data_v_o  out  1  record valid.
- data_yumi_i  in  1  consumer takes the record.
- data_id_o  out  reason_width_lp  entry id.
- data_count_o  out  cnt_width_p  count for that entry.
- data_last_o  out  1  final record of the dump.
- err_o  out  1  sticky; an out-of-range reason code was seen.

## Operation
Counting:
- Counting is active whenever reset_li=1 and freeze_i=0.
- If instret_i=1, the instret counter increments and any stall input that cycle is ignored. Retire takes priority over stall.
- Else, if stall_v_i=1 and stall_reason_i<num_reasons_p, counter[stall_reason_i] increments.
- Else, if stall_v_i=1 and the code is out of range, err_o is set and no counter changes.
- Counters saturate at 2^cnt_width_p-1. They never wrap.

FSM states are IDLE and DUMP.
- IDLE:
  - dump_ready_o=1.
  - On dump_v_i & dump_ready_o, copy all live counters to the shadow bank and zero the live counters.
  - If an event arrives in the accept cycle, it lands in the fresh live bank as count 1. It is not in the snapshot.
  - Load idx to 0 and go to DUMP.
- DUMP:
  - dump_ready_o=0 and data_v_o=1.
  - data_id_o=idx and data_count_o=shadow[idx].
  - data_last_o = (idx==num_reasons_p).
  - On data_yumi_i, idx increments. On yumi while last, go to IDLE.
  - Counting continues into the live bank throughout DUMP.
- dump_v_i while in DUMP is ignored; it is not queued.
- err_o clears only on reset.

## Timing
- Reset values: FSM=IDLE, all live and shadow counters=0, idx=0, dump_ready_o=1, data_v_o=0, data_id_o=0, data_count_o=0, data_last_o=0, err_o=0.
- Reset is asynchronous. If reset_li falls mid-DUMP, the block returns to IDLE immediately and all state is lost.
- Event-to-counter latency is 1 cycle: the count is visible in a snapshot taken the next cycle or later.
- data_v_o rises the cycle after dump accept.
- Drain throughput is one record per cycle with data_yumi_i held high. A full dump takes num_entries_lp cycles (22 at defaults), and dump_ready_o returns the cycle after the last yumi.
- data_* outputs are stable while data_v_o=1 and data_yumi_i=0.
- data_yumi_i while data_v_o=0 is illegal; assert on it in simulation.

## Structure
- `bp_stall_reason_e`, `bp_stall_reason_s`, and localparam `bp_num_stall_reasons_gp=21` move into `bp_common_pkg`. The profiler and this block share them.
- The FSM state enum stays local to the module.
- One sub-module, `bp_stall_sat_counter` (cnt_width_p, inc_i, clear_i, count_o, saturating), is instantiated num_entries_lp times.
- The shadow bank is a flop array indexed by idx.

## Test plan
- **Basic count:** reset, then drive reason 4 (dcache_miss) for 10 cycles and instret for 5, then dump with yumi=1. Expected: 22 records; id4=10, id21=5, others 0; data_last_o only on id21.
- **Priority:** instret_i=1 together with stall_v_i=1 and reason 16 for 3 cycles. Expected: id21=3, id16=0.
- **Snapshot boundary:** reason 9 is pulsed in the dump-accept cycle and during DUMP, then a second dump is issued. Expected: first dump id9 excludes those pulses; second dump id9 = pulses in accept cycle + during DUMP.
- **Backpressure and freeze:** yumi toggles 1/0 and freeze_i=1 during events. Expected: outputs hold steady while yumi=0, records stay in order 0..21, and frozen-cycle events are not counted.
- **Saturation and error:** with cnt_width_p=4, drive reason 0 for 20 cycles and reason 25 once. Expected: id0=15, err_o=1 and sticky across dumps.
- **Reset mid-dump:** assert reset_li=0 after 7 records. Expected: immediately data_v_o=0 and dump_ready_o=1; a following dump returns all zeros.

Source files
------------

// File: rtl/bp_common_pkg.sv
// Shared profiler types: the encoded stall-reason set and sizing helpers used
// by the stall pipe and the on-tile stall histogram reader.
package bp_common_pkg;

  localparam int bp_num_stall_reasons_gp = 21;

  typedef enum logic [4:0] {
    e_freeze          = 5'd0
    ,e_fe_queue_stall = 5'd1
    ,e_branch_override= 5'd2
    ,e_ret_override   = 5'd3
    ,e_dcache_miss    = 5'd4
    ,e_icache_miss    = 5'd5
    ,e_icache_rollback= 5'd6
    ,e_mispredict     = 5'd7
    ,e_control_haz    = 5'd8
    ,e_long_haz       = 5'd9
    ,e_data_haz       = 5'd10
    ,e_aux_dep        = 5'd11
    ,e_load_dep       = 5'd12
    ,e_mul_dep        = 5'd13
    ,e_fma_dep        = 5'd14
    ,e_sb_iraw_dep    = 5'd15
    ,e_sb_fraw_dep    = 5'd16
    ,e_struct_haz     = 5'd17
    ,e_exception      = 5'd18
    ,e_eret           = 5'd19
    ,e_unknown        = 5'd20
  } bp_stall_reason_e;

  typedef struct packed {
    logic             stall_v;
    bp_stall_reason_e reason;
    logic             instret;
  } bp_stall_reason_s;

  // Never returns 0, so a single-entry space still gets a 1-bit index.
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bp_stall_sat_counter.sv
// Saturating event counter. A clear wins over increment but keeps a
// coincident event, so nothing is lost across a snapshot.
module bp_stall_sat_counter #(
  parameter int cnt_width_p = 32
) (
  input  logic                   clk_i,
  input  logic                   reset_li,
  input  logic                   inc_i,
  input  logic                   clear_i,
  output logic [cnt_width_p-1:0] count_o
);

  logic [cnt_width_p-1:0] count_reg, count_next;

  always_comb begin
    count_next = count_reg;
    if (clear_i)
      count_next = cnt_width_p'(inc_i);
    else if (inc_i && !(&count_reg))
      count_next = count_reg + cnt_width_p'(1);
  end

  always_ff @(posedge clk_i or negedge reset_li) begin
    if (!reset_li) count_reg <= '0;
    else           count_reg <= count_next;
  end

  assign count_o = count_reg;

endmodule

// File: rtl/bp_stall_hist_reader.sv
// Per-reason stall histogram: live saturating counters, snapshot into a
// shadow bank on dump request, then drain (id, count) records over valid/yumi.
module bp_stall_hist_reader
  import bp_common_pkg::*;
#(
  parameter  int num_reasons_p   = bp_num_stall_reasons_gp,
  parameter  int cnt_width_p     = 32,
  localparam int reason_width_lp = safe_clog2(num_reasons_p + 1),
  localparam int num_entries_lp  = num_reasons_p + 1
) (
  input  logic                       clk_i,
  input  logic                       reset_li,
  input  logic                       freeze_i,
  input  logic                       stall_v_i,
  input  logic [reason_width_lp-1:0] stall_reason_i,
  input  logic                       instret_i,
  input  logic                       dump_v_i,
  output logic                       dump_ready_o,
  output logic                       data_v_o,
  input  logic                       data_yumi_i,
  output logic [reason_width_lp-1:0] data_id_o,
  output logic [cnt_width_p-1:0]     data_count_o,
  output logic                       data_last_o,
  output logic                       err_o
);

  typedef enum logic {e_idle, e_dump} state_e;

  state_e                     state_reg, state_next;
  logic [reason_width_lp-1:0] idx_reg, idx_next;
  logic                       err_reg;
  logic                       count_en, stall_bad, accept, is_last;
  logic [num_entries_lp-1:0]  inc;
  logic [cnt_width_p-1:0]     live_count [num_entries_lp];
  logic [cnt_width_p-1:0]     shadow_reg [num_entries_lp];

  assign count_en  = ~freeze_i;
  assign stall_bad = count_en & ~instret_i & stall_v_i
                   & (stall_reason_i >= reason_width_lp'(num_reasons_p));
  assign is_last   = (idx_reg == reason_width_lp'(num_reasons_p));

  // The top entry counts retires; a retire masks any stall that cycle.
  assign inc[num_reasons_p] = count_en & instret_i;

  genvar gi;
  generate
    for (gi = 0; gi < num_reasons_p; gi++) begin : g_inc
      assign inc[gi] = count_en & ~instret_i & stall_v_i
                     & (stall_reason_i == reason_width_lp'(gi));
    end

    for (gi = 0; gi < num_entries_lp; gi++) begin : g_cnt
      bp_stall_sat_counter #(.cnt_width_p(cnt_width_p)) u_cnt (
        .clk_i   (clk_i),
        .reset_li(reset_li),
        .inc_i   (inc[gi]),
        .clear_i (accept),
        .count_o (live_count[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk_i or negedge reset_li) begin
    if (!reset_li) begin
      for (int i = 0; i < num_entries_lp; i++) shadow_reg[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < num_entries_lp; i++) shadow_reg[i] <= live_count[i];
    end
  end

  always_ff @(posedge clk_i or negedge reset_li) begin
    if (!reset_li) begin
      state_reg <= e_idle;
      idx_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      err_reg   <= err_reg | stall_bad;
    end
  end

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    accept       = 1'b0;
    dump_ready_o = 1'b0;
    data_v_o     = 1'b0;
    data_id_o    = '0;
    data_count_o = '0;
    data_last_o  = 1'b0;
    case (state_reg)
      e_idle: begin
        dump_ready_o = 1'b1;
        if (dump_v_i) begin
          accept     = 1'b1;
          idx_next   = '0;
          state_next = e_dump;
        end
      end
      e_dump: begin
        data_v_o     = 1'b1;
        data_id_o    = idx_reg;
        data_count_o = shadow_reg[idx_reg];
        data_last_o  = is_last;
        if (data_yumi_i) begin
          if (is_last) begin
            idx_next   = '0;
            state_next = e_idle;
          end else begin
            idx_next = idx_reg + reason_width_lp'(1);
          end
        end
      end
      default: state_next = e_idle;
    endcase
  end

  assign err_o = err_reg;

  yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_li)
    data_yumi_i |-> data_v_o);

endmodule

// File: tb/tb_bp_stall_hist_reader.sv
// Scoreboard bench: a reference histogram predicts each dump's records,
// which are compared as the reader presents and releases them.
module tb_bp_stall_hist_reader;

  localparam int NR = 21;
  localparam int NE = NR + 1;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk_i = 1'b0;
  logic          reset_li = 1'b1;
  logic          freeze_i = 1'b0;
  logic          stall_v_i = 1'b0;
  logic [4:0]    stall_reason_i = '0;
  logic          instret_i = 1'b0;
  logic          dump_v_i = 1'b0;
  logic          dump_ready_o;
  logic          data_v_o;
  logic          data_yumi_i = 1'b0;
  logic [4:0]    data_id_o;
  logic [CW-1:0] data_count_o;
  logic          data_last_o;
  logic          err_o;

  bp_stall_hist_reader #(.num_reasons_p(NR), .cnt_width_p(CW)) dut (
    .clk_i         (clk_i),
    .reset_li      (reset_li),
    .freeze_i      (freeze_i),
    .stall_v_i     (stall_v_i),
    .stall_reason_i(stall_reason_i),
    .instret_i     (instret_i),
    .dump_v_i      (dump_v_i),
    .dump_ready_o  (dump_ready_o),
    .data_v_o      (data_v_o),
    .data_yumi_i   (data_yumi_i),
    .data_id_o     (data_id_o),
    .data_count_o  (data_count_o),
    .data_last_o   (data_last_o),
    .err_o         (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int id;
    int cnt;
    bit last;
  } rec_t;

  rec_t exp_q[$];
  int   model_live [NE];
  bit   model_err;
  bit   model_dump;
  int   n_tests;
  int   n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_inc(input int i);
    if (model_live[i] < CMAX) model_live[i]++;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NE; i++) model_live[i] = 0;
    model_err  = 1'b0;
    model_dump = 1'b0;
    exp_q.delete();
  endtask

  // One clock: drive inputs, check outputs before the edge, advance the model.
  task automatic cyc(input bit frz, input bit sv, input logic [4:0] rsn,
                     input bit ir, input bit dv, input bit ym);
    bit   was_dump;
    rec_t r;
    freeze_i       = frz;
    stall_v_i      = sv;
    stall_reason_i = rsn;
    instret_i      = ir;
    dump_v_i       = dv;
    data_yumi_i    = ym;
    was_dump       = model_dump;
    #1;
    check("dump_ready", 32'(dump_ready_o), 32'(!model_dump));
    check("data_v", 32'(data_v_o), 32'(model_dump));
    check("err", 32'(err_o), 32'(model_err));
    if (was_dump && exp_q.size() > 0) begin
      r = exp_q[0];
      check("rec_id", 32'(data_id_o), 32'(r.id));
      check("rec_count", 32'(data_count_o), 32'(r.cnt));
      check("rec_last", 32'(data_last_o), 32'(r.last));
      if (ym) begin
        void'(exp_q.pop_front());
        $display("[TB] record id=%0d count=%0d last=%0d", r.id, r.cnt, r.last);
        if (r.last) model_dump = 1'b0;
      end
    end
    if (!was_dump && dv) begin
      for (int i = 0; i < NE; i++) begin
        r.id = i; r.cnt = model_live[i]; r.last = (i == NR);
        exp_q.push_back(r);
        model_live[i] = 0;
      end
      model_dump = 1'b1;
    end
    if (!frz) begin
      if (ir) model_inc(NR);
      else if (sv) begin
        if (int'(rsn) < NR) model_inc(int'(rsn));
        else model_err = 1'b1;
      end
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // Drain the pending dump; optional backpressure, events and freeze meanwhile.
  task automatic drain(input bit toggle, input bit ev_on, input logic [4:0] rsn, input bit frz_on);
    int c;
    c = 0;
    while (model_dump && c < 200) begin
      cyc(frz_on && (c % 2 == 1), ev_on && (c % 3 == 0), rsn, 1'b0, (c == 1),
          toggle ? (c % 2 == 0) : 1'b1);
      c++;
    end
    check("drain_done", 32'(model_dump), 32'd0);
  endtask

  task automatic dump_all(input bit toggle);
    cyc(1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    drain(toggle, 1'b0, 5'd0, 1'b0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    model_clear();
    #2 reset_li = 1'b0;
    @(negedge clk_i);
    check("rst_ready", 32'(dump_ready_o), 32'd1);
    check("rst_v", 32'(data_v_o), 32'd0);
    check("rst_id", 32'(data_id_o), 32'd0);
    check("rst_count", 32'(data_count_o), 32'd0);
    check("rst_last", 32'(data_last_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    @(negedge clk_i);
    reset_li = 1'b1;

    // Basic count: reason 4 x10, instret x5
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)  cyc(1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    dump_all(1'b0);

    // Retire beats stall
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 5'd16, 1'b1, 1'b0, 1'b0);
    dump_all(1'b0);

    // Snapshot boundary on reason 9
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0);
    drain(1'b0, 1'b1, 5'd9, 1'b0);
    dump_all(1'b0);

    // Backpressure and freeze
    for (int i = 0; i < 6; i++) cyc(i % 2 == 1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    drain(1'b1, 1'b1, 5'd7, 1'b1);
    dump_all(1'b1);

    // Saturation and sticky error
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 5'd25, 1'b0, 1'b0, 1'b0);
    dump_all(1'b0);
    dump_all(1'b0);

    // Reset in the middle of a dump
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 5'd12, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    data_yumi_i = 1'b0;
    reset_li    = 1'b0;
    #1;
    check("midrst_v", 32'(data_v_o), 32'd0);
    check("midrst_ready", 32'(dump_ready_o), 32'd1);
    check("midrst_err", 32'(err_o), 32'd0);
    model_clear();
    @(negedge clk_i);
    reset_li = 1'b1;
    dump_all(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
